// File: rtl/clk_gen.sv
// Parameterised clock divider: clk_out toggles every HALF_PERIOD enabled clk_in cycles.
// Disable or active-low reset parks the output low and restarts the count.
module clk_gen #(
  parameter int unsigned HALF_PERIOD = 2
) (
  input  logic clk_in,
  input  logic reset,
  input  logic enable,
  output logic clk_out
);

  localparam int unsigned CNT_W =
    (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [CNT_W-1:0] TERM =
    CNT_W'(HALF_PERIOD - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             q;
  logic             q_nxt;

  // Dropping enable clears both count and output so a restart never
  // emits a short high pulse.
  always_comb begin
    cnt_nxt = '0;
    q_nxt   = 1'b0;
    if (enable) begin
      if (cnt == TERM) begin
        q_nxt = ~q;
      end else begin
        cnt_nxt = cnt + 1'b1;
        q_nxt   = q;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!reset) begin
      cnt <= '0;
      q   <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      q   <= q_nxt;
    end
  end

  assign clk_out = q;

endmodule

// File: tb/tb_clk_gen.sv
// Directed bench for clk_gen across several HALF_PERIOD settings.
// Inputs change 1ns after each rising edge; outputs sampled there too.
module tb_clk_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic r2 = 1'b0, e2 = 1'b0, o2;
  logic r1 = 1'b0, e1 = 1'b0, o1;
  logic r5 = 1'b0, e5 = 1'b0, o5;
  logic r3 = 1'b0, e3 = 1'b0, o3;
  logic r4 = 1'b0, e4 = 1'b0, o4;

  int pass_cnt = 0;
  int total    = 0;

  clk_gen #(.HALF_PERIOD(2)) u2 (
    .clk_in(clk), .reset(r2), .enable(e2), .clk_out(o2));
  clk_gen #(.HALF_PERIOD(1)) u1 (
    .clk_in(clk), .reset(r1), .enable(e1), .clk_out(o1));
  clk_gen #(.HALF_PERIOD(5)) u5 (
    .clk_in(clk), .reset(r5), .enable(e5), .clk_out(o5));
  clk_gen #(.HALF_PERIOD(3)) u3 (
    .clk_in(clk), .reset(r3), .enable(e3), .clk_out(o3));
  clk_gen #(.HALF_PERIOD(4)) u4 (
    .clk_in(clk), .reset(r4), .enable(e4), .clk_out(o4));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    r2 = 1'b0;
    e2 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (o2 !== 1'b0)
        $display("FAIL reset_out edge%0d got %b want 0", i, o2);
      else
        pass_cnt++;
    end
  endtask

  task automatic test_reset_priority();
    r2 = 1'b0;
    e2 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if (o2 !== 1'b0)
        $display("FAIL rst_prio edge%0d got %b want 0", i, o2);
      else
        pass_cnt++;
    end
  endtask

  task automatic test_div4();
    logic [7:0] exp_v;
    exp_v = 8'b0110_0110;
    r2 = 1'b1;
    e2 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      total++;
      if (o2 !== exp_v[7-i])
        $display("FAIL div4 edge%0d got %b want %b",
                 i, o2, exp_v[7-i]);
      else
        pass_cnt++;
    end
    r2 = 1'b0;
  endtask

  task automatic test_div2();
    r1 = 1'b0;
    e1 = 1'b1;
    tick();
    r1 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      total++;
      if (o1 !== ((i % 2) == 0))
        $display("FAIL div2 edge%0d got %b want %b",
                 i, o1, (i % 2) == 0);
      else
        pass_cnt++;
    end
    r1 = 1'b0;
  endtask

  task automatic test_div10();
    int   highs;
    int   rises;
    logic prev;
    logic exp_b;
    highs = 0;
    rises = 0;
    r5 = 1'b0;
    e5 = 1'b0;
    tick();
    prev = o5;
    r5 = 1'b1;
    e5 = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      exp_b = ((k / 5) % 2) == 1;
      total++;
      if (o5 !== exp_b)
        $display("FAIL div10 edge%0d got %b want %b", k, o5, exp_b);
      else
        pass_cnt++;
      if (o5 === 1'b1) highs++;
      if (o5 === 1'b1 && prev === 1'b0) rises++;
      prev = o5;
    end
    total++;
    if (highs != 20)
      $display("FAIL div10_high got %0d want 20", highs);
    else
      pass_cnt++;
    total++;
    if (rises != 4)
      $display("FAIL div10_rises got %0d want 4", rises);
    else
      pass_cnt++;
    r5 = 1'b0;
  endtask

  task automatic test_enable_drop();
    logic [3:0] exp_v;
    exp_v = 4'b0011;
    r3 = 1'b0;
    e3 = 1'b0;
    tick();
    r3 = 1'b1;
    e3 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (o3 !== exp_v[3-i])
        $display("FAIL en_run edge%0d got %b want %b",
                 i, o3, exp_v[3-i]);
      else
        pass_cnt++;
    end
    e3 = 1'b0;
    tick();
    total++;
    if (o3 !== 1'b0 || u3.cnt !== 2'd0)
      $display("FAIL en_drop got out=%b cnt=%0d want 0/0",
               o3, u3.cnt);
    else
      pass_cnt++;
    e3 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (o3 !== (i == 2))
        $display("FAIL en_restart edge%0d got %b want %b",
                 i, o3, i == 2);
      else
        pass_cnt++;
    end
    r3 = 1'b0;
  endtask

  task automatic test_mid_reset();
    logic [5:0] exp_v;
    exp_v = 6'b000111;
    r4 = 1'b0;
    e4 = 1'b0;
    tick();
    r4 = 1'b1;
    e4 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      total++;
      if (o4 !== exp_v[5-i])
        $display("FAIL mrst_run edge%0d got %b want %b",
                 i, o4, exp_v[5-i]);
      else
        pass_cnt++;
    end
    total++;
    if (u4.cnt !== 2'd2)
      $display("FAIL mrst_precnt got %0d want 2", u4.cnt);
    else
      pass_cnt++;
    r4 = 1'b0;
    tick();
    total++;
    if (o4 !== 1'b0 || u4.cnt !== 2'd0)
      $display("FAIL mrst_hit got out=%b cnt=%0d want 0/0",
               o4, u4.cnt);
    else
      pass_cnt++;
    r4 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (o4 !== (i == 3))
        $display("FAIL mrst_resume edge%0d got %b want %b",
                 i, o4, i == 3);
      else
        pass_cnt++;
    end
    r4 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_reset_priority();
    test_div4();
    test_div2();
    test_div10();
    test_enable_drop();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
